dec_fpu_ctl: RTL

DEC_FPU_CTL -- requirements
Module: dec_fpu_ctl

---
 rtl/dec_fpu_ctl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dec_fpu_ctl.sv
// FPU issue/writeback controller: grants one of two pipes, times the op latency, holds the result
// for writeback. Define RV_FPU_RR_ARB_EN for round-robin tie-breaking (default: i0 wins ties).
module dec_fpu_ctl #(
  parameter int unsigned LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             i0_fpu_req,
  input  logic [3:0]       i0_fpu_op,
  input  logic [LAT_W-1:0] i0_fpu_lat,
  input  logic [4:0]       i0_fpu_rd,
  input  logic             i1_fpu_req,
  input  logic [3:0]       i1_fpu_op,
  input  logic [LAT_W-1:0] i1_fpu_lat,
  input  logic [4:0]       i1_fpu_rd,
  input  logic             flush,
  input  logic             wb_ready,
  output logic             i0_grant,
  output logic             i1_grant,
  output logic             fpu_issue_valid,
  output logic [3:0]       fpu_issue_op,
  output logic             fpu_busy,
  output logic             fpu_wb_valid,
  output logic [4:0]       fpu_wb_rd,
  output logic             fpu_wb_pipe,
  output logic             i0_rd_hazard,
  output logic             i1_rd_hazard
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             pipe_q, pipe_d;
  logic             issue_q, issue_d;

  logic             can_grant;
  logic             sel_i1;
  logic             any_grant;
  logic [3:0]       g_op;
  logic [4:0]       g_rd;
  logic [LAT_W-1:0] g_lat;
  logic [LAT_W-1:0] g_cnt;

  // Reset gating keeps grants low while rst_l is asserted, even with requests pending.
  assign can_grant = rst_l && !flush &&
                     ((state_q == StIdle) || ((state_q == StWb) && wb_ready));

`ifdef RV_FPU_RR_ARB_EN
  logic rr_q, rr_d;
  // rr_q=1 prefers i1 on a tie.
  assign sel_i1 = i1_fpu_req && (!i0_fpu_req || rr_q);
`else
  assign sel_i1 = i1_fpu_req && !i0_fpu_req;
`endif

  assign i1_grant  = can_grant && sel_i1;
  assign i0_grant  = can_grant && i0_fpu_req && !sel_i1;
  assign any_grant = i0_grant || i1_grant;

  assign g_op  = sel_i1 ? i1_fpu_op  : i0_fpu_op;
  assign g_rd  = sel_i1 ? i1_fpu_rd  : i0_fpu_rd;
  assign g_lat = sel_i1 ? i1_fpu_lat : i0_fpu_lat;
  // Zero latency behaves as one cycle.
  assign g_cnt = (g_lat == '0) ? '0 : g_lat - LAT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    pipe_d  = pipe_q;
    issue_d = any_grant;
`ifdef RV_FPU_RR_ARB_EN
    rr_d    = rr_q;
    if (any_grant) rr_d = !sel_i1;
`endif
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_grant) state_d = StExec;
        end
        StExec: begin
          if (cnt_q == '0) state_d = StWb;
          else             cnt_d   = cnt_q - LAT_W'(1);
        end
        StWb: begin
          if (wb_ready) state_d = any_grant ? StExec : StIdle;
        end
        default: state_d = StIdle;
      endcase
      if (any_grant) begin
        cnt_d  = g_cnt;
        op_d   = g_op;
        rd_d   = g_rd;
        pipe_d = sel_i1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      pipe_q  <= 1'b0;
      issue_q <= 1'b0;
`ifdef RV_FPU_RR_ARB_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      pipe_q  <= pipe_d;
      issue_q <= issue_d;
`ifdef RV_FPU_RR_ARB_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign fpu_busy        = (state_q != StIdle);
  assign fpu_wb_valid    = (state_q == StWb);
  assign fpu_issue_valid = issue_q;
  assign fpu_issue_op    = op_q;
  assign fpu_wb_rd       = rd_q;
  assign fpu_wb_pipe     = pipe_q;
  assign i0_rd_hazard    = i0_fpu_req && fpu_busy && (i0_fpu_rd == rd_q);
  assign i1_rd_hazard    = i1_fpu_req && fpu_busy && (i1_fpu_rd == rd_q);

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_l)
    !(i0_grant && i1_grant));
  a_no_grant_on_flush: assert property (@(posedge clk) disable iff (!rst_l)
    flush |-> !(i0_grant || i1_grant));
`endif

endmodule
